// File: rtl/instr_encoder_pkg.sv
// Shared RV32I encoder definitions. The decoder uses the same type and opcode constants.
// Contents: instruction-type codes R_TYPE..J_TYPE, base opcodes, the S1 payload
// struct, and a sign-extension helper used by the optional immediate range checks.
package instr_encoder_pkg;

   localparam int unsigned XLEN = 32;

   // Instruction format codes, shared with the decoder
   localparam logic [2:0] R_TYPE = 3'd0;
   localparam logic [2:0] I_TYPE = 3'd1;
   localparam logic [2:0] S_TYPE = 3'd2;
   localparam logic [2:0] B_TYPE = 3'd3;
   localparam logic [2:0] U_TYPE = 3'd4;
   localparam logic [2:0] J_TYPE = 3'd5;

   // Base opcodes
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_REG    = 7'h33;

   // Decoded fields of one instruction, held in S1
   typedef struct packed {
      logic [2:0]      itype;
      logic [6:0]      opcode;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [2:0]      funct3;
      logic [6:0]      funct7;
      logic [XLEN-1:0] imm;
   } enc_fields_t;

   // True when v[31:lsb] are all equal, i.e. v fits a signed field of lsb+1 bits
   function automatic logic sext_fits(input logic [XLEN-1:0] v, input int unsigned lsb);
      logic [XLEN-1:0] sh;
      sh = XLEN'($signed(v) >>> lsb);
      return (&sh) || !(|sh);
   endfunction

endpackage

// File: rtl/imm_packer.sv
// Combinational field packer: maps instruction type, fields and immediate to a
// 32-bit RV32I word and flags entries that cannot be encoded.
// Ports: fields (in, enc_fields_t), word (out, 32), err (out, illegal type or range violation).
// Define INSTR_ENC_RANGE_CHECK_EN to reject immediates that do not fit their format;
// otherwise immediates are silently truncated and only illegal types are flagged.
module imm_packer
   import instr_encoder_pkg::*;
(
   input  enc_fields_t     fields,
   output logic [XLEN-1:0] word,
   output logic            err
);

   always_comb begin
      word = '0;
      err  = 1'b0;
      case (fields.itype)
         R_TYPE: word = {fields.funct7, fields.rs2, fields.rs1, fields.funct3,
                         fields.rd, fields.opcode};
         I_TYPE: begin
            word = {fields.imm[11:0], fields.rs1, fields.funct3, fields.rd, fields.opcode};
`ifdef INSTR_ENC_RANGE_CHECK_EN
            err  = !sext_fits(fields.imm, 11);
`endif
         end
         S_TYPE: begin
            word = {fields.imm[11:5], fields.rs2, fields.rs1, fields.funct3,
                    fields.imm[4:0], fields.opcode};
`ifdef INSTR_ENC_RANGE_CHECK_EN
            err  = !sext_fits(fields.imm, 11);
`endif
         end
         B_TYPE: begin
            word = {fields.imm[12], fields.imm[10:5], fields.rs2, fields.rs1,
                    fields.funct3, fields.imm[4:1], fields.imm[11], fields.opcode};
`ifdef INSTR_ENC_RANGE_CHECK_EN
            err  = fields.imm[0] || !sext_fits(fields.imm, 12);
`endif
         end
         U_TYPE: begin
            word = {fields.imm[31:12], fields.rd, fields.opcode};
`ifdef INSTR_ENC_RANGE_CHECK_EN
            err  = |fields.imm[11:0];
`endif
         end
         J_TYPE: begin
            word = {fields.imm[20], fields.imm[10:1], fields.imm[11], fields.imm[19:12],
                    fields.rd, fields.opcode};
`ifdef INSTR_ENC_RANGE_CHECK_EN
            err  = fields.imm[0] || !sext_fits(fields.imm, 20);
`endif
         end
         default: err = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I instruction encoder feeding the instruction-memory write port.
// S1 holds the decoded fields (packed by imm_packer); S2 holds the output word.
// Ports: clk, rst_n (async, active low), clr (sync flush); in_valid/in_ready with
// in_type, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm;
// out_valid/out_ready with out_instr, out_addr; err_pulse, err_cnt.
// Optional: INSTR_ENC_RANGE_CHECK_EN enables immediate range checks in imm_packer.
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2:0]           in_type,
   input  logic [6:0]           in_opcode,
   input  logic [4:0]           in_rd,
   input  logic [4:0]           in_rs1,
   input  logic [4:0]           in_rs2,
   input  logic [2:0]           in_funct3,
   input  logic [6:0]           in_funct7,
   input  logic [31:0]          in_imm,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_instr,
   output logic [31:0]          out_addr,
   output logic                 err_pulse,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   enc_fields_t     in_fields;
   enc_fields_t     s1_fields;
   logic            s1_valid;
   logic [XLEN-1:0] s1_word;
   logic            s1_err;
   logic            s2_valid;
   logic            s1_adv_c;
   logic            s2_fire_c;
   logic            in_fire_c;

   assign in_fields = '{itype: in_type, opcode: in_opcode, rd: in_rd, rs1: in_rs1,
                        rs2: in_rs2, funct3: in_funct3, funct7: in_funct7, imm: in_imm};

   imm_packer u_imm_packer (
      .fields (s1_fields),
      .word   (s1_word),
      .err    (s1_err)
   );

   // Erroneous entries leave S1 unconditionally since they never occupy S2
   assign s2_fire_c = s2_valid && out_ready;
   assign s1_adv_c  = s1_valid && (!s2_valid || out_ready || s1_err);
   assign in_ready  = rst_n && !clr && (!s1_valid || s1_adv_c);
   assign in_fire_c = in_valid && in_ready;
   assign out_valid = s2_valid;
   assign err_pulse = s1_valid && s1_err && !clr;

   // S1: capture decoded fields
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_fields <= '0;
      end else if (clr) begin
         s1_valid  <= 1'b0;
      end else if (in_fire_c) begin
         s1_valid  <= 1'b1;
         s1_fields <= in_fields;
      end else if (s1_adv_c) begin
         s1_valid  <= 1'b0;
      end
   end

   // S2: output word; out_addr is the running address of the word held here
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid  <= 1'b0;
         out_instr <= '0;
         out_addr  <= BASE_ADDR;
      end else if (clr) begin
         s2_valid  <= 1'b0;
         out_addr  <= BASE_ADDR;
      end else begin
         if (s2_fire_c) begin
            out_addr <= out_addr + 32'd4;
         end
         if (s1_adv_c && !s1_err) begin
            s2_valid  <= 1'b1;
            out_instr <= s1_word;
         end else if (s2_fire_c) begin
            s2_valid  <= 1'b0;
         end
      end
   end

   // Saturating count of dropped entries
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt <= '0;
      end else if (clr) begin
         err_cnt <= '0;
      end else if (err_pulse && (err_cnt != {ERR_CNT_W{1'b1}})) begin
         err_cnt <= err_cnt + ERR_CNT_W'(1);
      end
   end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RV32I instruction encoder: the inverse of the core's immediate/field decode path. Accepts an instruction type plus decoded fields (opcode, rd, rs1, rs2, funct3, funct7, 32-bit immediate), packs them into a 32-bit instruction word, and emits it with a word address for loading into instruction memory. It sits between the test/program-loader front end and the instruction-memory write port. It uses a two-stage valid/ready pipeline, an address counter and an error counter for immediates that cannot be encoded.

## Interface
- `BASE_ADDR`, 32'h0000_0000: address of the first emitted word after reset or `clr`.
- `ERR_CNT_W`, 8: width of the saturating error counter.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `clr` in 1: synchronous clear. Flushes the pipeline, reloads the address to `BASE_ADDR` and zeroes `err_cnt`.
- `in_valid` in 1: input fields valid.
- `in_ready` out 1: encoder accepts input this cycle.
- `in_type` in 3: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal. This is the same encoding the decoder uses.
- `in_opcode` in 7; `in_rd` in 5; `in_rs1` in 5; `in_rs2` in 5; `in_funct3` in 3; `in_funct7` in 7.
- `in_imm` in 32: byte-offset/immediate value, two's complement.
- `out_valid` out 1: encoded word valid.
- `out_ready` in 1: downstream accepts the word.
- `out_instr` out 32: encoded instruction.
- `out_addr` out 32: word address for `out_instr`.
- `err_pulse` out 1: one-cycle pulse when an input is dropped.
- `err_cnt` out `ERR_CNT_W`: count of dropped inputs, saturating.

## Operation
- **Packing:** bits [6:0] are always `in_opcode`.
  - R: funct7[31:25], rs2[24:20], rs1[19:15], funct3[14:12], rd[11:7].
  - I: imm[11:0]→[31:20], rs1, funct3, rd.
  - S: imm[11:5]→[31:25], rs2, rs1, funct3, imm[4:0]→[11:7].
  - B: imm[12]→31, imm[10:5]→[30:25], rs2, rs1, funct3, imm[4:1]→[11:8], imm[11]→7.
  - U: imm[31:12]→[31:12], rd.
  - J: imm[20]→31, imm[10:1]→[30:21], imm[11]→20, imm[19:12]→[19:12], rd.
- Fields not used by a type are ignored.
- **Stage 1 (S1):** registers the inputs and computes the packed word and an error flag.
- **Stage 2 (S2):** output register holding `out_instr`/`out_addr`.
- **Errors:** an illegal type, or a failed range check, marks the S1 entry as erroneous.
  - An erroneous entry is never transferred to S2.
  - In the cycle it leaves S1: `err_pulse`=1 and `err_cnt` increments, saturating at all-ones.
  - The address does not advance.
- **Address counter:** advances by 4 on each output handshake (`out_valid && out_ready`). It wraps modulo 2^32.
- **Reset values:** `in_ready`=0 while `rst_n`=0; `out_valid`=0, `out_instr`=0, `out_addr`=`BASE_ADDR`, `err_pulse`=0, `err_cnt`=0.

## Timing
- **Latency:** input handshake at cycle N gives `out_valid` at N+2, provided S2 is free.
- **Throughput:** 1 word/cycle with `out_ready` held high.
- **Ready logic:**
  - `in_ready` = !`clr` && (S1 empty || S1 advances this cycle).
  - S1 advances when S2 is empty, or S2 handshakes, or the S1 entry is erroneous.
- **Backpressure:** with `out_ready`=0 the pipeline holds at most 2 entries, then `in_ready`=0.
  - `out_instr` and `out_addr` are stable while `out_valid && !out_ready`.
- **`clr`:** takes priority over every other event.
  - Any pending output is discarded with no handshake.
  - An input offered in the same cycle is not accepted.
  - In the next cycle `out_valid`=0 and `out_addr`=`BASE_ADDR`.
- **Async reset mid-transfer:** all state is lost immediately and outputs return to reset values. No partial word is emitted.
- **Same-cycle events:** an error pulse and an output handshake may occur in the same cycle; each has its own effect.

## Configuration
- `INSTR_ENC_RANGE_CHECK_EN` defined: immediate range checks are active.
  - I/S: imm[31:11] must all be equal.
  - B: imm[0]=0 and imm[31:12] all equal.
  - J: imm[0]=0 and imm[31:20] all equal.
  - U: imm[11:0]=0.
  - A violation is a drop.
- `INSTR_ENC_RANGE_CHECK_EN` undefined:
  - Immediates are truncated silently.
  - Only illegal `in_type` values cause drops.
  - `err_cnt`/`err_pulse` still exist.

## Structure
- **Shared package** holds the type constants R_TYPE..J_TYPE (3'd0..3'd5), which the decoder also uses, plus the opcode constants OP_LUI, OP_JAL, OP_BRANCH, OP_STORE, OP_IMM and OP_REG.
- **Sub-module `imm_packer`:** purely combinational. Maps type, fields and imm to the word plus the range-error flag, and is instantiated in S1.

## Test plan
- **I-type:** type=1, opcode=0x13, rd=1, rs1=0, f3=0, imm=5 → `out_instr`=0x0050_0093 at +2 cycles, `out_addr`=0x0.
- **J-type:** type=5, opcode=0x6F, rd=1, imm=0x800 → 0x0010_00EF. Following it with an I-type word gives `out_addr`=0x4.
- **B-type:** type=3, opcode=0x63, rs1=1, rs2=2, f3=0, imm=0xFFFF_FFFC → 0xFE20_8EE3.
- **Range error:** macro defined, I-type imm=0x800.
  - Response: no `out_valid`, one `err_pulse`, `err_cnt`=1.
  - The next valid word still gets the unchanged address.
- **Backpressure:** three inputs with `out_ready`=0 for 5 cycles.
  - `in_ready` drops after 2 accepted.
  - After release the words come out in order at addresses 0x0, 0x4, 0x8.
- **Clear and reset:** `clr` with S2 full and `in_valid`=1.
  - Input is not accepted; next cycle `out_valid`=0 and `out_addr`=`BASE_ADDR`.
  - Asserting `rst_n`=0 mid-stream forces all outputs to their reset values asynchronously.
